// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem byte-stream bootloader.
// Holds the FSM state encoding, the error codes and the frame start byte.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_COUNT   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // States in which a frame is in progress and the idle timer runs.
  function automatic logic is_active(state_t s);
    return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, bundled together.
// master = byte source / imem owner side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) ();

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  imem_wren;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_addr,
    input  imem_wdata,
    input  imem_wren
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_addr,
    output imem_wdata,
    output imem_wren
  );

endinterface

// File: rtl/imem_loader_idle_timer.sv
// Down-counting idle timer: reloads on clear or while disabled, flags the
// CYCLES-th consecutive enabled cycle without a clear.
module idle_timer #(
  parameter int CYCLES = 65536
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(CYCLES);
  localparam logic [W-1:0] TERM = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear || !enable) begin
      cnt <= LOAD;
    end else if (cnt > TERM) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A transfer on the terminal cycle suppresses expiry.
  assign expired = enable && !clear && (cnt == TERM);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream bootloader: packs big-endian words into imem, verifies an
// XOR checksum and releases the processor hold only on a good image.
//
// state      | meaning
// ST_IDLE    | hunting for MAGIC, other bytes dropped
// ST_CNT_HI  | expecting COUNT high byte
// ST_CNT_LO  | expecting COUNT low byte, range check
// ST_PAYLOAD | packing payload bytes, one imem write per word
// ST_CHECK   | expecting checksum byte
// ST_DONE    | image good, cpu released, waiting for rearm
// ST_ERROR   | frame rejected, err_code held, waiting for rearm
module imem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 65536
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rearm,
  imem_loader_if.slave   bus,
  output logic           cpu_hold,
  output logic           load_done,
  output logic [1:0]     err_code
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  state_t                state;
  logic [7:0]            cnt_hi;
  logic [16:0]           words_left;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-9:0] shift;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [7:0]            csum;
  logic                  last_pending;

  logic        xfer;
  logic        timeout;
  logic [16:0] count_new;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign count_new = {1'b0, cnt_hi, bus.byte_data};

  idle_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (xfer),
    .enable  (is_active(state)),
    .expired (timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt_hi         <= '0;
      words_left     <= '0;
      byte_cnt       <= '0;
      shift          <= '0;
      word_idx       <= '0;
      csum           <= '0;
      last_pending   <= 1'b0;
      bus.byte_ready <= 1'b1;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.imem_wren  <= 1'b0;
      cpu_hold       <= 1'b1;
      load_done      <= 1'b0;
      err_code       <= ERR_NONE;
    end else begin
      bus.imem_wren <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (xfer && bus.byte_data == MAGIC) begin
            state    <= ST_CNT_HI;
            csum     <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end

        ST_CNT_HI: begin
          if (xfer) begin
            cnt_hi <= bus.byte_data;
            csum   <= csum ^ bus.byte_data;
            state  <= ST_CNT_LO;
          end else if (timeout) begin
            state          <= ST_ERROR;
            err_code       <= ERR_TIMEOUT;
            bus.byte_ready <= 1'b0;
          end
        end

        ST_CNT_LO: begin
          if (xfer) begin
            csum <= csum ^ bus.byte_data;
            if (count_new > MAX_WORDS) begin
              state          <= ST_ERROR;
              err_code       <= ERR_COUNT;
              bus.byte_ready <= 1'b0;
            end else if (count_new == '0) begin
              state <= ST_CHECK;
            end else begin
              words_left <= count_new;
              state      <= ST_PAYLOAD;
            end
          end else if (timeout) begin
            state          <= ST_ERROR;
            err_code       <= ERR_TIMEOUT;
            bus.byte_ready <= 1'b0;
          end
        end

        ST_PAYLOAD: begin
          // The final word's write cycle stays in PAYLOAD with input stalled.
          if (last_pending) begin
            last_pending   <= 1'b0;
            bus.byte_ready <= 1'b1;
            state          <= ST_CHECK;
          end else if (xfer) begin
            csum     <= csum ^ bus.byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.imem_wren  <= 1'b1;
              bus.imem_addr  <= word_idx;
              bus.imem_wdata <= {shift, bus.byte_data};
              word_idx       <= word_idx + 1'b1;
              words_left     <= words_left - 17'd1;
              if (words_left == 17'd1) begin
                last_pending   <= 1'b1;
                bus.byte_ready <= 1'b0;
              end
            end else begin
              shift <= {shift[DATA_WIDTH-17:0], bus.byte_data};
            end
          end else if (timeout) begin
            state          <= ST_ERROR;
            err_code       <= ERR_TIMEOUT;
            bus.byte_ready <= 1'b0;
          end
        end

        ST_CHECK: begin
          if (xfer) begin
            bus.byte_ready <= 1'b0;
            if (bus.byte_data == csum) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= ST_ERROR;
              err_code <= ERR_CSUM;
            end
          end else if (timeout) begin
            state          <= ST_ERROR;
            err_code       <= ERR_TIMEOUT;
            bus.byte_ready <= 1'b0;
          end
        end

        ST_DONE, ST_ERROR: begin
          if (rearm) begin
            state          <= ST_IDLE;
            bus.byte_ready <= 1'b1;
            err_code       <= ERR_NONE;
            load_done      <= 1'b0;
            cpu_hold       <= 1'b1;
            csum           <= '0;
          end
        end

        default: begin
          state          <= ST_IDLE;
          bus.byte_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
